// File: rtl/conf_arb_pkg.sv
// conf_arb_pkg: shared definitions for the conf_merge_arb slice.
//   - arb_state_t : arbiter FSM states (IDLE/SEND/WAIT/RELEASE)
//   - idw_calc    : requester index width, never below one bit
//   - tcw_calc    : width of the WAIT-cycle counter able to hold TIMEOUT_CYC
package conf_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND    = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_t;

  function automatic int idw_calc(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic int tcw_calc(input int t);
    return (t > 0) ? $clog2(t + 1) : 1;
  endfunction

endpackage

// File: rtl/conf_merge_arb_rr_pick.sv
// rr_pick: combinational round-robin priority select.
// Ports:
//   i_req   in  N_REQ  request vector
//   i_ptr   in  IDW    index searched first; search continues upward with wrap
//   o_gnt   out N_REQ  one-hot grant (zero when no request)
//   o_idx   out IDW    index of the granted requester
//   o_valid out 1      at least one request present
module rr_pick
  import conf_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int IDW   = idw_calc(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDW-1:0]   i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic [IDW-1:0]   o_idx,
  output logic             o_valid
);

  logic [2*N_REQ-1:0] w_req2;
  logic [N_REQ-1:0]   w_rot;
  logic [N_REQ-1:0]   w_first;
  logic [N_REQ:0]     w_seen;
  logic [IDW-1:0]     w_cand [N_REQ];
  logic [IDW-1:0]     w_acc  [N_REQ+1];

  // Rotating the doubled vector puts requester (ptr+j) mod N at bit j,
  // so a plain lowest-bit-first scan gives round-robin order.
  assign w_req2 = {i_req, i_req};
  assign w_rot  = N_REQ'(w_req2 >> i_ptr);

  assign w_seen[0] = 1'b0;
  assign w_acc[0]  = '0;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_scan
    assign w_cand[gi]    = IDW'((int'(i_ptr) + gi) % N_REQ);
    assign w_first[gi]   = w_rot[gi] & ~w_seen[gi];
    assign w_seen[gi+1]  = w_seen[gi] | w_rot[gi];
    assign w_acc[gi+1]   = w_acc[gi] | ({IDW{w_first[gi]}} & w_cand[gi]);
  end

  assign o_valid = w_seen[N_REQ];
  assign o_idx   = w_acc[N_REQ];
  assign o_gnt   = o_valid ? (N_REQ'(1) << o_idx) : '0;

endmodule

// File: rtl/conf_merge_arb.sv
// conf_merge_arb: clocked round-robin sequencer sharing one downstream
// drive/free channel between N_REQ requesters, with sticky protocol errors.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   i_drive       per-requester one-cycle request pulse
//   o_free        per-requester one-cycle completion pulse
//   i_data        requester k word at [k*DATA_WIDTH +: DATA_WIDTH]
//   o_drive_next  one-cycle pulse to the consumer, o_data valid
//   i_free_next   consumer completion pulse (honoured only in WAIT)
//   o_data        registered word of the granted requester
//   o_grant_id    index of the current or last grant
//   o_busy        high whenever the FSM is not IDLE
//   i_clr_err     clears the sticky error flags
//   o_err_dup     sticky: request while the same request was still pending
//   o_timeout     sticky: WAIT lasted TIMEOUT_CYC cycles without a free
module conf_merge_arb
  import conf_arb_pkg::*;
#(
  parameter  int N_REQ       = 2,
  parameter  int DATA_WIDTH  = 128,
  parameter  int TIMEOUT_CYC = 1024,
  localparam int IDW         = idw_calc(N_REQ)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            i_drive,
  output logic [N_REQ-1:0]            o_free,
  input  logic [N_REQ*DATA_WIDTH-1:0] i_data,
  output logic                        o_drive_next,
  input  logic                        i_free_next,
  output logic [DATA_WIDTH-1:0]       o_data,
  output logic [IDW-1:0]              o_grant_id,
  output logic                        o_busy,
  input  logic                        i_clr_err,
  output logic                        o_err_dup,
  output logic                        o_timeout
);

  localparam int             CW       = tcw_calc(TIMEOUT_CYC);
  localparam logic [CW-1:0]  CNT_MAX  = CW'(TIMEOUT_CYC);
  localparam logic [CW-1:0]  CNT_LAST = (TIMEOUT_CYC > 0) ? CW'(TIMEOUT_CYC - 1) : '0;

  arb_state_t            r_state;
  arb_state_t            w_state_next;
  logic [N_REQ-1:0]      r_pending;
  logic [N_REQ-1:0]      w_gnt;
  logic [N_REQ-1:0]      w_clr;
  logic [IDW-1:0]        r_ptr;
  logic [IDW-1:0]        w_idx;
  logic [IDW-1:0]        r_grant_id;
  logic [DATA_WIDTH-1:0] r_data;
  logic [CW-1:0]         r_cnt;
  logic                  r_err_dup;
  logic                  r_timeout;
  logic                  w_valid;
  logic                  w_grant;
  logic                  w_dup_evt;
  logic                  w_to_evt;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_pick (
    .i_req   (r_pending),
    .i_ptr   (r_ptr),
    .o_gnt   (w_gnt),
    .o_idx   (w_idx),
    .o_valid (w_valid)
  );

  assign w_grant = (r_state == ST_IDLE) && w_valid;
  assign w_clr   = w_grant ? w_gnt : '0;

  // A bit being granted this cycle may be re-requested without error.
  assign w_dup_evt = |(i_drive & r_pending & ~w_clr);

  // Fires on the TIMEOUT_CYC-th WAIT cycle that sees no free; the counter
  // then saturates so the event cannot repeat within one transaction.
  assign w_to_evt = (TIMEOUT_CYC != 0) && (r_state == ST_WAIT) &&
                    !i_free_next && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    o_drive_next = 1'b0;
    o_free       = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_valid) w_state_next = ST_SEND;
      end
      ST_SEND: begin
        o_drive_next = 1'b1;
        w_state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_free_next) w_state_next = ST_RELEASE;
      end
      ST_RELEASE: begin
        o_free       = N_REQ'(1) << r_grant_id;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pending  <= '0;
      r_ptr      <= '0;
      r_grant_id <= '0;
      r_data     <= '0;
      r_cnt      <= '0;
      r_err_dup  <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      // Set wins over the grant clear, allowing back-to-back re-requests.
      r_pending <= (r_pending & ~w_clr) | i_drive;

      if (w_grant) begin
        r_data     <= i_data[w_idx*DATA_WIDTH +: DATA_WIDTH];
        r_grant_id <= w_idx;
        r_ptr      <= (w_idx == IDW'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
      end

      if (r_state == ST_RELEASE) begin
        r_cnt <= '0;
      end else if ((r_state == ST_WAIT) && !i_free_next && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (w_dup_evt)      r_err_dup <= 1'b1;
      else if (i_clr_err) r_err_dup <= 1'b0;

      if (w_to_evt)       r_timeout <= 1'b1;
      else if (i_clr_err) r_timeout <= 1'b0;
    end
  end

  assign o_busy     = (r_state != ST_IDLE);
  assign o_data     = r_data;
  assign o_grant_id = r_grant_id;
  assign o_err_dup  = r_err_dup;
  assign o_timeout  = r_timeout;

endmodule
